// File: rtl/pe_pkg.sv
// pe_pkg: shared mode constants, default widths and the
// saturating/wrapping add helper used by the PE datapath.
package pe_pkg;

   localparam logic MODE_WS = 1'b0;
   localparam logic MODE_OS = 1'b1;

   localparam int DEF_A_W = 8;
   localparam int DEF_W_W = 8;
   localparam int DEF_P_W = 24;

   // Operands are widened to ADD_W so the exact sum never overflows.
   localparam int ADD_W = 64;

   typedef struct packed {
      logic signed [ADD_W-1:0] sum;
      logic                    ovf;
   } add_res_t;

   function automatic add_res_t sat_add(
      input logic signed [ADD_W-1:0] a,
      input logic signed [ADD_W-1:0] b,
      input int                      w,
      input logic                    sat
   );
      logic signed [ADD_W-1:0] s;
      logic signed [ADD_W-1:0] hi;
      logic signed [ADD_W-1:0] lo;
      add_res_t                r;
      s     = a + b;
      hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo    = -(64'sd1 <<< (w - 1));
      r.ovf = (s > hi) || (s < lo);
      r.sum = s;
      if (sat && (s > hi)) r.sum = hi;
      if (sat && (s < lo)) r.sum = lo;
      return r;
   endfunction

endpackage

// File: rtl/pe_sat_add.sv
// pe_sat_add: P_W-bit signed adder, clamping (SAT=1) or wrapping
// (SAT=0), with an overflow indication in both cases.
module pe_sat_add
   import pe_pkg::*;
#(
   parameter int P_W = DEF_P_W,
   parameter int SAT = 1
) (
   input  logic signed [P_W-1:0] a,
   input  logic signed [P_W-1:0] b,
   output logic signed [P_W-1:0] sum,
   output logic                  ovf
);

   add_res_t res;

   always_comb begin
      res = sat_add(ADD_W'(a), ADD_W'(b), P_W, SAT != 0);
   end

   // Clamped results already fit; wrapped results keep the low bits.
   assign sum = res.sum[P_W-1:0];
   assign ovf = res.ovf;

endmodule

// File: rtl/pe_dbuf.sv
// pe_dbuf: systolic PE with double-buffered weight, two-stage MAC
// pipeline, weight-stationary and output-stationary modes.
module pe_dbuf
   import pe_pkg::*;
#(
   parameter int A_W = DEF_A_W,
   parameter int W_W = DEF_W_W,
   parameter int P_W = DEF_P_W,
   parameter int SAT = 1
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  EN,
   input  logic                  MODE,
   input  logic                  W_LOAD,
   input  logic signed [W_W-1:0] W_IN,
   input  logic                  W_SWAP,
   input  logic                  ENLeft,
   output logic                  ENRight,
   input  logic                  ENTop,
   output logic                  ENDown,
   input  logic signed [A_W-1:0] A_IN,
   output logic signed [A_W-1:0] A_OUT,
   input  logic signed [P_W-1:0] PSUM_IN,
   output logic signed [P_W-1:0] PSUM_OUT,
   input  logic                  DRAIN,
   input  logic                  ACC_CLR,
   output logic                  OVF
);

   localparam int M_W = A_W + W_W;

   if (P_W < M_W) begin : g_pw_chk
      $error("pe_dbuf: P_W must be >= A_W + W_W");
   end
   if (P_W > ADD_W - 1) begin : g_pw_max
      $error("pe_dbuf: P_W too wide for the adder helper");
   end

   logic signed [W_W-1:0] w_shadow;
   logic signed [W_W-1:0] w_active;
   logic signed [M_W-1:0] prod;

   logic signed [A_W-1:0] a_r1;
   logic signed [P_W-1:0] psum_r1;
   logic signed [P_W-1:0] prod_r1;
   logic                  enl_r1;
   logic                  ent_r1;
   logic signed [P_W-1:0] acc;

   logic signed [P_W-1:0] ws_sum;
   logic signed [P_W-1:0] acc_sum;
   logic                  ws_ovf;
   logic                  acc_ovf;

   assign prod = M_W'(A_IN) * M_W'(w_active);

   pe_sat_add #(.P_W(P_W), .SAT(SAT)) u_ws_add (
      .a   (psum_r1),
      .b   (prod_r1),
      .sum (ws_sum),
      .ovf (ws_ovf)
   );

   pe_sat_add #(.P_W(P_W), .SAT(SAT)) u_acc_add (
      .a   (acc),
      .b   (prod_r1),
      .sum (acc_sum),
      .ovf (acc_ovf)
   );

   // Same-cycle load+swap: active takes the old shadow value.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         w_shadow <= '0;
         w_active <= '0;
      end else begin
         if (W_LOAD) w_shadow <= W_IN;
         if (W_SWAP) w_active <= w_shadow;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         a_r1     <= '0;
         psum_r1  <= '0;
         prod_r1  <= '0;
         enl_r1   <= 1'b0;
         ent_r1   <= 1'b0;
         A_OUT    <= '0;
         ENRight  <= 1'b0;
         ENDown   <= 1'b0;
         PSUM_OUT <= '0;
      end else if (EN) begin
         a_r1    <= A_IN;
         psum_r1 <= PSUM_IN;
         prod_r1 <= P_W'(prod);
         enl_r1  <= ENLeft;
         ent_r1  <= ENTop;
         A_OUT   <= a_r1;
         ENRight <= enl_r1;
         ENDown  <= ent_r1;
         if (MODE == MODE_WS) PSUM_OUT <= ws_sum;
         else if (DRAIN)      PSUM_OUT <= acc;
         else                 PSUM_OUT <= psum_r1;
      end else begin
         a_r1     <= '0;
         psum_r1  <= '0;
         prod_r1  <= '0;
         enl_r1   <= 1'b0;
         ent_r1   <= 1'b0;
         A_OUT    <= '0;
         ENRight  <= 1'b0;
         ENDown   <= 1'b0;
         PSUM_OUT <= '0;
      end
   end

   // Clear wins over accumulate and drain.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         acc <= '0;
         OVF <= 1'b0;
      end else if (ACC_CLR) begin
         acc <= '0;
         OVF <= 1'b0;
      end else if (EN) begin
         if (MODE == MODE_WS) begin
            if (ws_ovf) OVF <= 1'b1;
         end else if (DRAIN) begin
            acc <= enl_r1 ? prod_r1 : '0;
         end else if (enl_r1) begin
            acc <= acc_sum;
            if (acc_ovf) OVF <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pe_dbuf.sv
// tb_pe_dbuf: vector table with scoreboard for WS streaming, plus
// directed sequences for buffering, OS, saturation, EN and reset.
module tb_pe_dbuf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rstn, en, mode, w_load, w_swap;
   logic signed [7:0]  w_in, a_in;
   logic               enl, ent, drain, acc_clr;
   logic signed [23:0] psum_in;
   logic signed [15:0] psum16;

   logic               enr, endn, ovf;
   logic signed [7:0]  a_out;
   logic signed [23:0] psum_out;

   logic               enr_s, endn_s, ovf_s;
   logic signed [7:0]  a_out_s;
   logic signed [15:0] psum_out_s;
   logic               enr_w, endn_w, ovf_w;
   logic signed [7:0]  a_out_w;
   logic signed [15:0] psum_out_w;

   pe_dbuf dut (
      .CLK(clk), .RSTN(rstn), .EN(en), .MODE(mode),
      .W_LOAD(w_load), .W_IN(w_in), .W_SWAP(w_swap),
      .ENLeft(enl), .ENRight(enr), .ENTop(ent), .ENDown(endn),
      .A_IN(a_in), .A_OUT(a_out),
      .PSUM_IN(psum_in), .PSUM_OUT(psum_out),
      .DRAIN(drain), .ACC_CLR(acc_clr), .OVF(ovf)
   );

   pe_dbuf #(.P_W(16), .SAT(1)) dut_s (
      .CLK(clk), .RSTN(rstn), .EN(en), .MODE(mode),
      .W_LOAD(w_load), .W_IN(w_in), .W_SWAP(w_swap),
      .ENLeft(enl), .ENRight(enr_s), .ENTop(ent), .ENDown(endn_s),
      .A_IN(a_in), .A_OUT(a_out_s),
      .PSUM_IN(psum16), .PSUM_OUT(psum_out_s),
      .DRAIN(drain), .ACC_CLR(acc_clr), .OVF(ovf_s)
   );

   pe_dbuf #(.P_W(16), .SAT(0)) dut_w (
      .CLK(clk), .RSTN(rstn), .EN(en), .MODE(mode),
      .W_LOAD(w_load), .W_IN(w_in), .W_SWAP(w_swap),
      .ENLeft(enl), .ENRight(enr_w), .ENTop(ent), .ENDown(endn_w),
      .A_IN(a_in), .A_OUT(a_out_w),
      .PSUM_IN(psum16), .PSUM_OUT(psum_out_w),
      .DRAIN(drain), .ACC_CLR(acc_clr), .OVF(ovf_w)
   );

   int tests = 0;
   int fails = 0;
   bit mon_on = 1'b0;

   typedef struct {
      logic signed [7:0]  w;
      logic signed [7:0]  a;
      logic               et;
      logic signed [23:0] psum;
      logic signed [23:0] exp;
   } vec_t;

   typedef struct {
      logic signed [7:0]  a;
      logic               et;
      logic signed [23:0] psum;
   } exp_t;

   vec_t vecs[7];
   exp_t sb[$];

   task automatic chk(input string name,
                      input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      enl = 0; ent = 0; a_in = 0; psum_in = 0; psum16 = 0;
      w_load = 0; w_swap = 0; drain = 0; acc_clr = 0;
   endtask

   task automatic set_w(input logic signed [7:0] w);
      w_in = w; w_load = 1; tick(); w_load = 0;
      w_swap = 1; tick(); w_swap = 0;
   endtask

   always @(negedge clk) begin
      if (mon_on && enr) begin
         exp_t e;
         if (sb.size() == 0) begin
            chk("sb_unexpected", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("ws_psum", psum_out, e.psum);
            chk("ws_a", a_out, e.a);
            chk("ws_down", endn, e.et);
         end
      end
   end

   initial begin
      rstn = 0; en = 0; mode = 0; w_in = 0;
      idle();
      vecs[0] = '{w: 8'sd3,   a: -8'sd4,  et: 1'b1,
                  psum: 24'sd100,     exp: 24'sd88};
      vecs[1] = '{w: 8'h80,   a: 8'h80,   et: 1'b0,
                  psum: 24'sd0,       exp: 24'sd16384};
      vecs[2] = '{w: 8'sd127, a: 8'h80,   et: 1'b1,
                  psum: -24'sd5,      exp: -24'sd16261};
      vecs[3] = '{w: 8'sd5,   a: 8'sd10,  et: 1'b0,
                  psum: 24'sd8388600, exp: 24'sd8388607};
      vecs[4] = '{w: -8'sd1,  a: 8'sd127, et: 1'b1,
                  psum: 24'h800000,   exp: 24'h800000};
      vecs[5] = '{w: 8'sd0,   a: 8'sd55,  et: 1'b0,
                  psum: 24'sd12345,   exp: 24'sd12345};
      vecs[6] = '{w: 8'sd1,   a: -8'sd1,  et: 1'b1,
                  psum: 24'sd1,       exp: 24'sd0};

      #12;
      chk("rst_a_out", a_out, 0);
      chk("rst_psum", psum_out, 0);
      chk("rst_enr", enr, 0);
      chk("rst_endn", endn, 0);
      chk("rst_ovf", ovf, 0);
      rstn = 1;
      tick();
      en = 1;

      mon_on = 1;
      foreach (vecs[i]) begin
         set_w(vecs[i].w);
         a_in = vecs[i].a; psum_in = vecs[i].psum;
         enl = 1; ent = vecs[i].et;
         sb.push_back('{a: vecs[i].a, et: vecs[i].et, psum: vecs[i].exp});
         tick();
         idle();
      end
      for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
      chk("sb_drained", sb.size(), 0);
      tick();
      mon_on = 0;
      chk("ovf_sticky", ovf, 1);
      acc_clr = 1; tick(); acc_clr = 0;
      chk("ovf_clr", ovf, 0);

      set_w(8'sd2);
      w_in = 8'sd5; w_load = 1; w_swap = 1;
      a_in = 8'sd10; enl = 1;
      tick();
      idle(); w_swap = 1;
      chk("lat1_valid", enr, 0);
      tick();
      idle();
      chk("lat2_valid", enr, 1);
      chk("dbuf_old_w", psum_out, 20);
      chk("lat2_a_out", a_out, 10);
      a_in = 8'sd10; enl = 1; tick();
      idle(); tick();
      chk("dbuf_new_w", psum_out, 50);

      set_w(8'sd4);
      mode = 1; acc_clr = 1; tick(); acc_clr = 0;
      for (int i = 1; i <= 3; i++) begin
         a_in = 8'(i); enl = 1; tick();
      end
      idle(); tick();
      drain = 1; tick(); drain = 0;
      chk("os_drain", psum_out, 24);
      drain = 1; tick(); drain = 0;
      chk("os_acc_zero", psum_out, 0);
      chk("os_ovf", ovf, 0);

      a_in = 8'sd5; enl = 1; ent = 1; tick();
      en = 0; a_in = 8'sd6; tick();
      en = 1; a_in = 8'sd7; tick();
      idle();
      chk("endrop_a", a_out, 0);
      chk("endrop_enr", enr, 0);
      chk("endrop_endn", endn, 0);
      chk("endrop_psum", psum_out, 0);
      tick();
      chk("enresume_a", a_out, 7);
      chk("enresume_enr", enr, 1);
      drain = 1; tick(); drain = 0;
      chk("endrop_acc", psum_out, 28);

      mode = 0; acc_clr = 1; tick(); acc_clr = 0;
      set_w(8'sd1);
      chk("sat_ovf_pre", ovf_s, 0);
      chk("wrap_ovf_pre", ovf_w, 0);
      a_in = 8'sd1; psum_in = 24'sd32767; psum16 = 16'sd32767;
      enl = 1; tick();
      idle(); tick();
      chk("sat_psum", psum_out_s, 32767);
      chk("sat_ovf", ovf_s, 1);
      chk("wrap_psum", psum_out_w, -32768);
      chk("wrap_ovf", ovf_w, 1);
      chk("main_no_sat", psum_out, 32768);

      mode = 1; a_in = 8'sd3; enl = 1; ent = 1;
      tick(); tick();
      chk("pre_rst_a", a_out, 3);
      #3 rstn = 0;
      #1;
      chk("arst_a_out", a_out, 0);
      chk("arst_psum", psum_out, 0);
      chk("arst_enr", enr, 0);
      chk("arst_endn", endn, 0);
      chk("arst_ovf_s", ovf_s, 0);
      #2 rstn = 1;
      idle(); tick();
      drain = 1; tick(); drain = 0;
      chk("arst_acc_gone", psum_out, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
